// File: rtl/apb_reg_responder.sv
// APB register responder: CTRL / SCRATCH / STATUS / COUNT behind a three-state
// APB slave FSM with a programmable number of wait states per ACCESS phase.
//
// state  | meaning
// IDLE   | no transfer; waiting for psel=1, penable=0
// SETUP  | address seen; load wait counter, snapshot read data and error flag
// ACCESS | wait counter runs down; pready=1 once it reaches zero
module apb_reg_responder #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [1:0]  r_ctrl;
  logic [31:0] r_scratch;
  logic [31:0] r_count;
  logic        r_ovf;
  logic        r_st_err;

  logic        w_dec_err;
  logic [31:0] w_rd_val;
  logic        w_ready;
  logic        w_complete;
  logic        w_commit;
  logic        w_err_set;
  logic        w_wrap;
  logic [1:0]  w_sts_clr;

  // Misaligned or out-of-range addresses and writes to the read-only COUNT fail.
  assign w_dec_err  = (|paddr[31:4]) || (|paddr[1:0]) || (pwrite && (paddr[3:2] == 2'd3));
  assign w_ready    = (r_state == ST_ACCESS) && (r_wait_cnt == 4'd0);
  assign w_complete = w_ready && psel && penable;
  assign w_commit   = w_complete && pwrite && !r_err;
  assign w_err_set  = w_complete && r_err;
  assign w_wrap     = r_ctrl[0] && (r_count == 32'hFFFF_FFFF);
  assign w_sts_clr  = (w_commit && (paddr[3:2] == 2'd2)) ? pwdata[1:0] : 2'b00;

  // Outputs depend only on registered state, never on psel/penable directly.
  assign pready  = w_ready;
  assign pslverr = w_ready && r_err;
  assign prdata  = w_ready ? r_rdata : 32'd0;
  assign irq     = r_ovf && r_ctrl[1];

  // Read mux for the decoded register, sampled into r_rdata on the SETUP edge.
  always_comb begin
    w_rd_val = 32'd0;
    case (paddr[3:2])
      2'd0:    w_rd_val = {30'd0, r_ctrl};
      2'd1:    w_rd_val = r_scratch;
      2'd2:    w_rd_val = {30'd0, r_st_err, r_ovf};
      default: w_rd_val = r_count;
    endcase
  end

  // Next-state logic; dropping psel in ACCESS aborts the transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (psel && !penable) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (!psel)        w_state_nxt = ST_IDLE;
        else if (w_ready) w_state_nxt = penable ? ST_IDLE : ST_SETUP;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, wait counter and the per-transfer read/error snapshot.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_SETUP) begin
        r_wait_cnt <= LP_WAIT;
        r_rdata    <= w_dec_err ? 32'd0 : w_rd_val;
        r_err      <= w_dec_err;
      end else if ((r_state == ST_ACCESS) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // CTRL and SCRATCH take writes only on a clean completion edge.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_ctrl    <= 2'd0;
      r_scratch <= 32'd0;
    end else if (w_commit) begin
      case (paddr[3:2])
        2'd0:    r_ctrl    <= pwdata[1:0];
        2'd1:    r_scratch <= pwdata;
        default: ;
      endcase
    end
  end

  // Free-running COUNT while enabled; wraps to zero and flags overflow.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_count <= 32'd0;
    else if (r_ctrl[0]) r_count <= r_count + 32'd1;
  end

  // STATUS W1C bits; a set on the same edge as a clear keeps the bit high.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_ovf    <= 1'b0;
      r_st_err <= 1'b0;
    end else begin
      r_ovf    <= (r_ovf && !w_sts_clr[0]) || w_wrap;
      r_st_err <= (r_st_err && !w_sts_clr[1]) || w_err_set;
    end
  end

endmodule
